// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct values, FSM state encoding and ALU operations
// for the multicycle MIPS core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  // 32-bit ALU; overflow is ignored and slt compares signed
  function automatic logic [31:0] alu(input alu_op_t fn_op, input logic [31:0] a,
                                      input logic [31:0] b);
    case (fn_op)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
      default: return a + b;
    endcase
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, two async read ports, one sync write
// port, $0 reads as zero and ignores writes, async active-low clear.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);

  logic [31:0] regs [0:31];

  // clear on reset, write port discards $0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && (wa != 5'd0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS subset (add/sub/and/or/slt, addi, lw,
// sw, beq, j) with one shared ALU and one unified ready-handshake memory port.
// Optional: define MIPS_BNE_EN to make bne (opcode 6'h05) legal.
//
// state     | meaning
// ST_FETCH  | request instruction at pc; on ready latch IR, pc += 4
// ST_DECODE | read rs/rt into A/B, precompute branch target; illegal -> HALT
// ST_EXEC   | ALU op; branches/jumps retire here
// ST_MEM    | load/store transfer; sw retires on ready
// ST_WB     | register write-back, retire
// ST_HALT   | terminal until reset
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req,
  output logic            mem_we,
  output logic [PC_W-1:0] mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ready,
  input  logic [31:0]     mem_rdata,
  output logic [PC_W-1:0] pc,
  output logic            retire,
  output logic            halted
);

`ifdef MIPS_BNE_EN
  localparam logic BNE_EN = 1'b1;
`else
  localparam logic BNE_EN = 1'b0;
`endif

  state_t          state_q, state_d;
  logic            run_q;
  logic [PC_W-1:0] pc_q;
  logic [31:0]     ir_q, mdr_q, a_q, b_q, aluout_q;
  logic [5:0]      op, fn;
  logic [4:0]      rs, rt, rd;
  logic [15:0]     imm;
  logic [25:0]     tgt;
  logic [31:0]     sext, pc_ext, jt, rd1, rd2, alu_a, alu_b, alu_y;
  alu_op_t         alu_op, r_op;
  logic            is_r, is_br, fn_ok, legal, br_taken, xfer;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [31:0]     rf_wd;
  logic            unused_ok;

  assign op     = ir_q[31:26];
  assign rs     = ir_q[25:21];
  assign rt     = ir_q[20:16];
  assign rd     = ir_q[15:11];
  assign fn     = ir_q[5:0];
  assign imm    = ir_q[15:0];
  assign tgt    = ir_q[25:0];
  assign sext   = {{16{imm[15]}}, imm};
  assign pc_ext = 32'(pc_q);
  assign jt     = {pc_ext[31:28], tgt, 2'b00};
  assign is_r   = (op == OP_RTYPE);
  assign is_br  = (op == OP_BEQ) || (BNE_EN && (op == OP_BNE));
  assign legal  = (is_r && fn_ok) || (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW) ||
                  (op == OP_BEQ) || (op == OP_J) || (BNE_EN && (op == OP_BNE));
  assign unused_ok = ^{ir_q[10:6], pc_ext, jt};

  // R-type funct to ALU operation
  always_comb begin
    r_op  = ALU_ADD;
    fn_ok = 1'b1;
    case (fn)
      FN_ADD:  r_op = ALU_ADD;
      FN_SUB:  r_op = ALU_SUB;
      FN_AND:  r_op = ALU_AND;
      FN_OR:   r_op = ALU_OR;
      FN_SLT:  r_op = ALU_SLT;
      default: fn_ok = 1'b0;
    endcase
  end

  // shared ALU operand select: pc+4 in FETCH, branch target in DECODE, execute in EXEC
  always_comb begin
    alu_a  = pc_ext;
    alu_b  = 32'd4;
    alu_op = ALU_ADD;
    case (state_q)
      ST_DECODE: alu_b = sext << 2;
      ST_EXEC: begin
        alu_a  = a_q;
        alu_b  = (is_r || is_br) ? b_q : sext;
        alu_op = is_r ? r_op : (is_br ? ALU_SUB : ALU_ADD);
      end
      default: ;
    endcase
  end

  assign alu_y    = alu(alu_op, alu_a, alu_b);
  assign br_taken = (alu_y == 32'd0) ^ (op == OP_BNE);

  // run_q holds the request off for the first cycle after reset
  assign mem_req   = run_q && ((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign mem_we    = mem_req && (state_q == ST_MEM) && (op == OP_SW);
  assign mem_addr  = !mem_req ? '0 :
                     (state_q == ST_MEM) ? {aluout_q[PC_W-1:2], 2'b00} : {pc_q[PC_W-1:2], 2'b00};
  assign mem_wdata = mem_we ? b_q : '0;
  assign xfer      = mem_req && mem_ready;
  assign pc        = pc_q;
  assign halted    = (state_q == ST_HALT);

  // next state and retire pulse
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH:  if (xfer) state_d = ST_DECODE;
      ST_DECODE: state_d = legal ? ST_EXEC : ST_HALT;
      ST_EXEC: begin
        if (is_r || (op == OP_ADDI)) begin
          state_d = ST_WB;
        end else if ((op == OP_LW) || (op == OP_SW)) begin
          state_d = ST_MEM;
        end else begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        if (xfer) begin
          if (op == OP_SW) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
  end

  // state register and post-reset start flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_FETCH;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // PC, IR, MDR, A, B and ALUOut updates per state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      mdr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      aluout_q <= '0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (xfer) begin
            ir_q <= mem_rdata;
            pc_q <= alu_y[PC_W-1:0];
          end
        end
        ST_DECODE: begin
          a_q      <= rd1;
          b_q      <= rd2;
          aluout_q <= alu_y;
        end
        ST_EXEC: begin
          if (op == OP_J) begin
            pc_q <= jt[PC_W-1:0];
          end else if (is_br) begin
            if (br_taken) pc_q <= aluout_q[PC_W-1:0];
          end else begin
            aluout_q <= alu_y;
          end
        end
        ST_MEM: if (xfer && (op == OP_LW)) mdr_q <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign rf_we = (state_q == ST_WB);
  assign rf_wa = is_r ? rd : rt;
  assign rf_wd = (op == OP_LW) ? mdr_q : aluout_q;

  mips_regfile u_rf (
    .clk (clk),
    .rst (rst),
    .ra1 (rs),
    .ra2 (rt),
    .rd1 (rd1),
    .rd2 (rd2),
    .we  (rf_we),
    .wa  (rf_wa),
    .wd  (rf_wd)
  );

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: directed programs against a memory model whose
// data region (addresses below 0x40) can be given extra ready latency.
module tb_mips_multicycle_core;

  localparam int         PC_W   = 8;
  localparam logic [7:0] RST_PC = 8'h40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [7:0]  pc;
  logic        retire, halted;

  logic [31:0] mem [0:63];
  int data_lat  = 0;
  int lat_cnt   = 0;
  int checks    = 0;
  int errors    = 0;
  int st_cycles = 0;
  int cyc;

  mips_multicycle_core #(.PC_W(PC_W), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .pc        (pc),
    .retire    (retire),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  // memory responder: ready after data_lat wait cycles for data-region addresses
  always @(negedge clk) begin
    if (mem_ready) lat_cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
    if (mem_req) begin
      if (lat_cnt >= ((mem_addr < 8'h40) ? data_lat : 0)) begin
        mem_ready = 1'b1;
        if (mem_we) mem[mem_addr[7:2]] = mem_wdata;
        else        mem_rdata = mem[mem_addr[7:2]];
      end else begin
        lat_cnt++;
      end
    end else begin
      lat_cnt = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  // runs until retire; returns cycles spent, then steps past the retiring edge
  task automatic run_instr(output int n, input logic [7:0] st_addr, input logic [31:0] st_data);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      sample();
      n++;
      if (mem_req && mem_we) begin
        st_cycles++;
        chk("st_addr", 32'(mem_addr), 32'(st_addr));
        chk("st_wdata", mem_wdata, st_data);
      end
      seen = retire;
    end
    chk("retire_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_halt();
    int n;
    n = 0;
    while (!halted && n < 40) begin
      sample();
      n++;
    end
    chk("halt_seen", 32'(halted), 32'd1);
  endtask

  task automatic start_reset(input int lat);
    sample();
    rst = 1'b0;
    data_lat = lat;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    sample();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // 1: addi/addi/add, retire every 4 cycles, then illegal halts
    start_reset(0);
    chk("rst_pc", 32'(pc), 32'h40);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    mem[16] = 32'h2001_0005;  // addi $1,$0,5
    mem[17] = 32'h2002_0007;  // addi $2,$0,7
    mem[18] = 32'h0022_1820;  // add  $3,$1,$2
    release_reset();
    run_instr(cyc, 8'h0, 32'h0);
    run_instr(cyc, 8'h0, 32'h0);
    chk("addi_cycles", 32'(cyc), 32'd4);
    run_instr(cyc, 8'h0, 32'h0);
    chk("add_cycles", 32'(cyc), 32'd4);
    chk("reg1", dut.u_rf.regs[1], 32'd5);
    chk("reg2", dut.u_rf.regs[2], 32'd7);
    chk("reg3", dut.u_rf.regs[3], 32'd12);
    wait_halt();
    chk("halt_pc", 32'(pc), 32'h50);
    chk("halt_mem_req", 32'(mem_req), 32'd0);

    // 2: sw/lw with 3 wait cycles on data accesses
    start_reset(3);
    mem[16] = 32'h2003_000C;  // addi $3,$0,12
    mem[17] = 32'hAC03_0008;  // sw   $3,8($0)
    mem[18] = 32'h8C04_0008;  // lw   $4,8($0)
    release_reset();
    run_instr(cyc, 8'h0, 32'h0);
    st_cycles = 0;
    run_instr(cyc, 8'h08, 32'd12);
    chk("sw_cycles", 32'(cyc), 32'd7);
    chk("sw_req_cycles", 32'(st_cycles), 32'd4);
    chk("mem_word2", mem[2], 32'd12);
    run_instr(cyc, 8'h0, 32'h0);
    chk("lw_cycles", 32'(cyc), 32'd8);
    chk("reg4_lw", dut.u_rf.regs[4], 32'd12);

    // 3a: j to 0x10, beq taken back to itself
    start_reset(0);
    mem[16] = 32'h2001_0005;  // addi $1,$0,5
    mem[17] = 32'h0800_0004;  // j 0x10
    mem[4]  = 32'h1021_FFFF;  // beq $1,$1,-1
    release_reset();
    run_instr(cyc, 8'h0, 32'h0);
    run_instr(cyc, 8'h0, 32'h0);
    chk("j_cycles", 32'(cyc), 32'd3);
    chk("j_pc", 32'(pc), 32'h10);
    run_instr(cyc, 8'h0, 32'h0);
    chk("beq_t_cycles", 32'(cyc), 32'd3);
    chk("beq_t_pc", 32'(pc), 32'h10);
    run_instr(cyc, 8'h0, 32'h0);
    chk("beq_t_pc2", 32'(pc), 32'h10);

    // 3b: beq not taken falls through to 0x14
    start_reset(0);
    mem[16] = 32'h2001_0005;  // addi $1,$0,5
    mem[17] = 32'h0800_0004;  // j 0x10
    mem[4]  = 32'h1020_0001;  // beq $1,$0,+1
    release_reset();
    run_instr(cyc, 8'h0, 32'h0);
    run_instr(cyc, 8'h0, 32'h0);
    run_instr(cyc, 8'h0, 32'h0);
    chk("beq_nt_cycles", 32'(cyc), 32'd3);
    chk("beq_nt_pc", 32'(pc), 32'h14);
    wait_halt();
    chk("beq_nt_halt_pc", 32'(pc), 32'h18);

    // 4: j to 0xFC, fall-through wraps pc to 0x00
    start_reset(0);
    mem[16] = 32'h0800_003F;  // j 0xFC
    mem[63] = 32'h2005_0001;  // addi $5,$0,1
    release_reset();
    run_instr(cyc, 8'h0, 32'h0);
    chk("j_fc_pc", 32'(pc), 32'hFC);
    run_instr(cyc, 8'h0, 32'h0);
    chk("wrap_pc", 32'(pc), 32'h00);
    chk("reg5", dut.u_rf.regs[5], 32'd1);
    wait_halt();
    chk("wrap_halt_pc", 32'(pc), 32'h04);

    // 5: opcode 3F halts right after DECODE, no further requests
    start_reset(0);
    mem[16] = 32'h2001_0005;  // addi $1,$0,5
    mem[17] = 32'hFC00_0000;  // illegal
    release_reset();
    run_instr(cyc, 8'h0, 32'h0);
    sample();
    chk("ill_fetch_req", 32'(mem_req), 32'd1);
    sample();
    chk("ill_decode_halted", 32'(halted), 32'd0);
    sample();
    chk("ill_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("ill_hold_req", 32'(mem_req), 32'd0);
      chk("ill_hold_pc", 32'(pc), 32'h48);
    end

    // 5b: bne legal only with MIPS_BNE_EN
    start_reset(0);
    mem[16] = 32'h2001_0005;  // addi $1,$0,5
    mem[17] = 32'h1420_FFFE;  // bne $1,$0,-2
    release_reset();
    run_instr(cyc, 8'h0, 32'h0);
`ifdef MIPS_BNE_EN
    run_instr(cyc, 8'h0, 32'h0);
    chk("bne_cycles", 32'(cyc), 32'd3);
    chk("bne_pc", 32'(pc), 32'h40);
`else
    wait_halt();
    chk("bne_halt_pc", 32'(pc), 32'h48);
`endif

    // 6: reset during lw wait drops request; $0 stays zero
    start_reset(5);
    mem[2]  = 32'h0000_1234;
    mem[16] = 32'h2000_0009;  // addi $0,$0,9
    mem[17] = 32'h8C04_0008;  // lw $4,8($0)
    release_reset();
    run_instr(cyc, 8'h0, 32'h0);
    chk("reg0", dut.u_rf.regs[0], 32'd0);
    sample();
    sample();
    sample();
    sample();
    chk("lw_wait_req", 32'(mem_req), 32'd1);
    chk("lw_wait_addr", 32'(mem_addr), 32'h08);
    rst = 1'b0;
    #1;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_pc", 32'(pc), 32'h40);
    chk("rst_mid_reg4", dut.u_rf.regs[4], 32'd0);
    sample();
    rst = 1'b1;
    sample();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
